// File: rtl/mem_port_arbiter_if.sv
// Handshake bundle between the fetch unit, the MEM stage, the shared
// memory and the port arbiter. The arbiter uses the slave view; the core
// and memory side together use the master view.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 6
);
    // Instruction-fetch port
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_flush;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;

    // Data-access port
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_func3;
    logic [31:0]       d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;

    // Unified memory command / read data
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_func3;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output if_req, if_addr, if_flush,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_func3, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_addr, mem_read, mem_write, mem_func3, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  if_req, if_addr, if_flush,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_func3, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_addr, mem_read, mem_write, mem_func3, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one unified memory between instruction fetch and the MEM stage.
// Data accesses win conflicts unless fetch has been denied STARVE_MAX
// cycles in a row. Read data returns one cycle after the grant and is
// steered to whichever port owned the access.
module mem_port_arbiter #(
    parameter int ADDR_W     = 6,
    parameter int STARVE_MAX = 4
) (
    input  logic                risc_clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int               CNT_W   = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RESP_IF = 2'd1,
        RESP_D  = 2'd2
    } state_t;

    state_t           state_reg;
    logic             owner_store_reg;
    logic [CNT_W-1:0] starve_cnt_reg;

    logic if_eligible;
    logic starved;
    logic if_gnt_int;
    logic d_gnt_int;

    // Only the low address bits reach the memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W], bus.d_addr[31:ADDR_W]};

    // Same-cycle grant: data first, fetch when starved (unless being flushed).
    always_comb begin
        if_eligible = bus.if_req & ~bus.if_flush;
        starved     = (starve_cnt_reg == CNT_MAX);
        d_gnt_int   = ~rst & bus.d_req & ~(starved & if_eligible);
        if_gnt_int  = ~rst & if_eligible & (~bus.d_req | starved);
        bus.d_gnt   = d_gnt_int;
        bus.if_gnt  = if_gnt_int;
    end

    // Memory command for the granted owner; all-zero when nothing is granted.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.mem_func3 = 3'b000;
        bus.mem_wdata = 32'h0;
        if (if_gnt_int) begin
            bus.mem_addr  = bus.if_addr[ADDR_W-1:0];
            bus.mem_read  = 1'b1;
            bus.mem_func3 = 3'b010;
        end else if (d_gnt_int) begin
            bus.mem_addr  = bus.d_addr[ADDR_W-1:0];
            bus.mem_read  = ~bus.d_we;
            bus.mem_write = bus.d_we;
            bus.mem_func3 = bus.d_func3;
            bus.mem_wdata = bus.d_wdata;
        end
    end

    // Response FSM: remembers who owns the access whose data arrives next cycle.
    always_ff @(posedge risc_clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            owner_store_reg <= 1'b0;
        end else if (if_gnt_int) begin
            state_reg       <= RESP_IF;
            owner_store_reg <= 1'b0;
        end else if (d_gnt_int) begin
            state_reg       <= RESP_D;
            owner_store_reg <= bus.d_we;
        end else begin
            state_reg       <= IDLE;
            owner_store_reg <= 1'b0;
        end
    end

    // Count consecutive cycles in which a pending fetch was refused.
    always_ff @(posedge risc_clk) begin
        if (rst) begin
            starve_cnt_reg <= '0;
        end else if (!bus.if_req || if_gnt_int) begin
            starve_cnt_reg <= '0;
        end else if (starve_cnt_reg != CNT_MAX) begin
            starve_cnt_reg <= starve_cnt_reg + 1'b1;
        end
    end

    // Steer returning data; a flush drops a fetch response, reset drops any.
    always_comb begin
        bus.if_rvalid = ~rst & (state_reg == RESP_IF) & ~bus.if_flush;
        bus.d_rvalid  = ~rst & (state_reg == RESP_D);
        bus.if_rdata  = bus.if_rvalid ? bus.mem_rdata : 32'h0;
        bus.d_rdata   = (bus.d_rvalid & ~owner_store_reg) ? bus.mem_rdata : 32'h0;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: a reference arbitration model
// predicts grants and memory commands, and a scoreboard queue carries the
// expected response from the grant cycle to the following cycle.
module tb_mem_port_arbiter;
    localparam int ADDR_W     = 6;
    localparam int STARVE_MAX = 4;

    logic risc_clk = 1'b0;
    logic rst      = 1'b1;
    always #5 risc_clk = ~risc_clk;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W)) bus();

    mem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .risc_clk (risc_clk),
        .rst      (rst),
        .bus      (bus)
    );

    // Memory: write on the edge, registered read; junk when not reading.
    logic [31:0] mem_arr [64];
    always @(posedge risc_clk) begin
        if (bus.mem_write) mem_arr[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_read)  bus.mem_rdata <= mem_arr[bus.mem_addr];
        else               bus.mem_rdata <= 32'hA5A5_5A5A;
    end

    typedef struct {
        bit          is_if;
        bit          is_store;
        logic [31:0] data;
    } resp_t;

    resp_t       sb_q[$];
    logic [31:0] sb_mem [64];
    int          model_cnt = 0;
    int          vec_cnt   = 0;
    int          miss_cnt  = 0;
    int          cyc       = 0;
    bit          last_eg_i;
    bit          last_eg_d;
    logic        seen_if_gnt;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // One clock cycle of stimulus plus all checks for that cycle.
    task automatic step(input bit ireq, input logic [31:0] iaddr, input bit iflush,
                        input bit dreq, input bit dwe, input logic [2:0] df3,
                        input logic [31:0] daddr, input logic [31:0] dwdata);
        bit          if_ok, starved, eg_i, eg_d;
        bit          e_rd, e_wr, e_iv, e_dv;
        logic [2:0]  e_f3;
        logic [5:0]  e_ad;
        logic [31:0] e_wd, e_id, e_dd;
        resp_t       e;
        @(posedge risc_clk);
        #1;
        rst          = 1'b0;
        bus.if_req   = ireq;
        bus.if_addr  = iaddr;
        bus.if_flush = iflush;
        bus.d_req    = dreq;
        bus.d_we     = dwe;
        bus.d_func3  = df3;
        bus.d_addr   = daddr;
        bus.d_wdata  = dwdata;
        if_ok   = ireq && !iflush;
        starved = (model_cnt == STARVE_MAX);
        eg_d    = dreq && !(starved && if_ok);
        eg_i    = if_ok && (!dreq || starved);
        e_rd = 1'b0; e_wr = 1'b0; e_f3 = 3'b000; e_ad = 6'h0; e_wd = 32'h0;
        if (eg_i) begin
            e_rd = 1'b1; e_f3 = 3'b010; e_ad = iaddr[5:0];
        end else if (eg_d) begin
            e_rd = !dwe; e_wr = dwe; e_f3 = df3; e_ad = daddr[5:0]; e_wd = dwdata;
        end
        e_iv = 1'b0; e_dv = 1'b0; e_id = 32'h0; e_dd = 32'h0;
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            if (e.is_if) begin
                e_iv = !iflush;
                e_id = iflush ? 32'h0 : e.data;
            end else begin
                e_dv = 1'b1;
                e_dd = e.is_store ? 32'h0 : e.data;
            end
        end
        @(negedge risc_clk);
        check_val("if_gnt",    32'(bus.if_gnt),    32'(eg_i));
        check_val("d_gnt",     32'(bus.d_gnt),     32'(eg_d));
        check_val("mem_read",  32'(bus.mem_read),  32'(e_rd));
        check_val("mem_write", 32'(bus.mem_write), 32'(e_wr));
        check_val("mem_func3", 32'(bus.mem_func3), 32'(e_f3));
        check_val("mem_addr",  32'(bus.mem_addr),  32'(e_ad));
        if (!eg_i) check_val("mem_wdata", bus.mem_wdata, e_wd);
        check_val("if_rvalid", 32'(bus.if_rvalid), 32'(e_iv));
        check_val("if_rdata",  bus.if_rdata,       e_id);
        check_val("d_rvalid",  32'(bus.d_rvalid),  32'(e_dv));
        check_val("d_rdata",   bus.d_rdata,        e_dd);
        if (eg_i) begin
            e.is_if = 1'b1; e.is_store = 1'b0; e.data = sb_mem[iaddr[5:0]];
            sb_q.push_back(e);
        end else if (eg_d) begin
            e.is_if = 1'b0; e.is_store = dwe; e.data = sb_mem[daddr[5:0]];
            sb_q.push_back(e);
            if (dwe) sb_mem[daddr[5:0]] = dwdata;
        end
        if (!ireq || eg_i)              model_cnt = 0;
        else if (model_cnt < STARVE_MAX) model_cnt++;
        last_eg_i   = eg_i;
        last_eg_d   = eg_d;
        seen_if_gnt = bus.if_gnt;
        $display("cycle %0d: if_req=%0b d_req=%0b flush=%0b -> if_gnt=%0b d_gnt=%0b if_rvalid=%0b d_rvalid=%0b",
                 cyc, ireq, dreq, iflush, bus.if_gnt, bus.d_gnt, bus.if_rvalid, bus.d_rvalid);
        cyc++;
    endtask

    // Reset cycles with both requests asserted: everything must stay quiet.
    task automatic do_reset(input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(posedge risc_clk);
            #1;
            rst          = 1'b1;
            bus.if_req   = 1'b1;
            bus.if_addr  = 32'h0000_0008;
            bus.if_flush = 1'b0;
            bus.d_req    = 1'b1;
            bus.d_we     = 1'b1;
            bus.d_func3  = 3'b010;
            bus.d_addr   = 32'h0000_0030;
            bus.d_wdata  = 32'hFFFF_FFFF;
            @(negedge risc_clk);
            check_val("rst_if_gnt",    32'(bus.if_gnt),    32'h0);
            check_val("rst_d_gnt",     32'(bus.d_gnt),     32'h0);
            check_val("rst_mem_cmd",   32'({bus.mem_read, bus.mem_write, bus.mem_func3}), 32'h0);
            check_val("rst_mem_addr",  32'(bus.mem_addr),  32'h0);
            check_val("rst_mem_wdata", bus.mem_wdata,      32'h0);
            check_val("rst_rvalid",    32'({bus.if_rvalid, bus.d_rvalid}), 32'h0);
            check_val("rst_rdata",     bus.if_rdata | bus.d_rdata, 32'h0);
            $display("cycle %0d: reset", cyc);
            cyc++;
        end
        sb_q.delete();
        model_cnt = 0;
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
    endtask

    initial begin
        int          if_grants;
        bit          p_ireq, p_dreq, p_dwe, p_flush;
        logic [31:0] p_iaddr, p_daddr, p_wdata;
        logic [2:0]  p_f3;

        bus.if_req = 1'b0; bus.if_addr = 32'h0; bus.if_flush = 1'b0;
        bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_func3 = 3'b000;
        bus.d_addr = 32'h0; bus.d_wdata = 32'h0;
        for (int i = 0; i < 64; i++) begin
            mem_arr[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
            sb_mem[i]  = mem_arr[i];
        end
        mem_arr[8]  = 32'h0050_0093; sb_mem[8]  = 32'h0050_0093;
        mem_arr[32] = 32'hDEAD_BEEF; sb_mem[32] = 32'hDEAD_BEEF;

        do_reset(2);
        idle();

        // Simple fetch of word 8, response next cycle.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        idle();

        // Conflict: load 0x20 wins, fetch follows next cycle.
        step(1'b1, 32'h4, 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        step(1'b1, 32'h4, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        idle();

        // Both requests held: fetch must get exactly 2 grants in 10 cycles.
        if_grants = 0;
        for (int i = 0; i < 12; i++) begin
            step(1'b1, 32'h0C, 1'b0, 1'b1, 1'b0, 3'b010, 32'h24, 32'h0);
            if (i < 10 && seen_if_gnt === 1'b1) if_grants++;
        end
        check_val("fetch_grants_0_9", 32'(if_grants), 32'd2);
        idle();

        // Store then load back the same word.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1, 3'b010, 32'h10, 32'h1234_5678);
        idle();
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h10, 32'h0);
        idle();

        // Flush kills a pending fetch response and a new fetch grant.
        step(1'b1, 32'h8, 1'b0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        // Flush does not disturb an in-flight data response.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        step(1'b1, 32'h8, 1'b1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0);
        idle();

        // Reset right after a data grant drops the response.
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 3'b010, 32'h20, 32'h0);
        do_reset(1);
        idle();

        // Randomised traffic honouring hold-until-granted.
        p_ireq = 1'b0; p_dreq = 1'b0; p_dwe = 1'b0;
        p_iaddr = 32'h0; p_daddr = 32'h0; p_wdata = 32'h0; p_f3 = 3'b000;
        for (int i = 0; i < 60; i++) begin
            if (!p_ireq && $urandom_range(0, 3) != 0) begin
                p_ireq  = 1'b1;
                p_iaddr = $urandom();
            end
            if (!p_dreq && $urandom_range(0, 2) != 0) begin
                p_dreq  = 1'b1;
                p_dwe   = 1'($urandom_range(0, 1));
                p_daddr = $urandom();
                p_wdata = $urandom();
                p_f3    = 3'($urandom_range(0, 7));
            end
            p_flush = ($urandom_range(0, 7) == 0);
            step(p_ireq, p_iaddr, p_flush, p_dreq, p_dwe, p_f3, p_daddr, p_wdata);
            if (last_eg_i) p_ireq = 1'b0;
            if (last_eg_d) p_dreq = 1'b0;
        end
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end
endmodule
